// File: rtl/disp_sched.sv
// Display scheduler: walks the six clock modes, picks the display word, blinks the
// field under edit and lets alarm/countdown events take over the hex8 display.
module disp_sched #(
    parameter int MCNT_BLINK   = 25_000_000-1,
    parameter int MCNT_S       = 50_000_000-1,
    parameter int ALARM_HOLD_S = 10
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Mode_key,
    input  logic        Field_key,
    input  logic        Ack_key,
    input  logic        Alarm_hit,
    input  logic        Countdown_done,
    input  logic [31:0] Clock_data,
    input  logic [31:0] Calendar_data,
    input  logic [31:0] Alarm_data,
    input  logic [31:0] Countdown_data,
    output logic [31:0] Disp_Data,
    output logic [2:0]  Mode,
    output logic        Edit_en,
    output logic [1:0]  Edit_field,
    output logic        Ring
);

    localparam int BW = (MCNT_BLINK > 0) ? $clog2(MCNT_BLINK + 1) : 1;
    localparam int PW = (MCNT_S > 0) ? $clog2(MCNT_S + 1) : 1;
    localparam int HW = (ALARM_HOLD_S > 1) ? $clog2(ALARM_HOLD_S) : 1;

    localparam logic [BW-1:0] BLINK_LAST = BW'(MCNT_BLINK);
    localparam logic [PW-1:0] PRE_LAST   = PW'(MCNT_S);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(ALARM_HOLD_S - 1);

    typedef enum logic [2:0] {
        M_CLOCK      = 3'd0,
        M_CLOCK_C    = 3'd1,
        M_CALENDAR   = 3'd2,
        M_CALENDAR_C = 3'd3,
        M_ALARM      = 3'd4,
        M_COUNTER_D  = 3'd5
    } mode_t;

    mode_t          r_mode, w_mode_next;
    logic [1:0]     r_field, w_field_next;
    logic           r_ring, w_ring_next;
    logic           r_src_alarm, w_src_alarm_next;
    logic [BW-1:0]  r_blink, w_blink_next;
    logic           r_phase, w_phase_next;
    logic [PW-1:0]  r_pre, w_pre_next;
    logic [HW-1:0]  r_hold, w_hold_next;
    logic [31:0]    r_disp, w_disp_next;

    logic           w_hit, w_edit_mode, w_mode_acc, w_field_acc;
    logic           w_pre_wrap, w_hold_done;
    logic [31:0]    w_src_word;

    // Keys are swallowed while ringing and on the cycle a hit arrives.
    assign w_hit       = Alarm_hit | Countdown_done;
    assign w_edit_mode = (r_mode == M_CLOCK_C) || (r_mode == M_CALENDAR_C) || (r_mode == M_ALARM);
    assign w_mode_acc  = Mode_key & ~r_ring & ~w_hit;
    assign w_field_acc = Field_key & ~Mode_key & ~r_ring & ~w_hit & w_edit_mode;
    assign w_pre_wrap  = (r_pre == PRE_LAST);
    assign w_hold_done = r_ring & w_pre_wrap & (r_hold == HOLD_LAST);

    always_comb begin
        w_mode_next  = r_mode;
        w_field_next = r_field;
        case (r_mode)
            M_CLOCK:      if (w_mode_acc) w_mode_next = M_CLOCK_C;
            M_CLOCK_C:    if (w_mode_acc) w_mode_next = M_CALENDAR;
            M_CALENDAR:   if (w_mode_acc) w_mode_next = M_CALENDAR_C;
            M_CALENDAR_C: if (w_mode_acc) w_mode_next = M_ALARM;
            M_ALARM:      if (w_mode_acc) w_mode_next = M_COUNTER_D;
            M_COUNTER_D:  if (w_mode_acc) w_mode_next = M_CLOCK;
            default:      w_mode_next = M_CLOCK;
        endcase
        if (w_mode_next != r_mode) begin
            w_field_next = 2'd0;
        end else if (w_field_acc) begin
            w_field_next = (r_field >= 2'd2) ? 2'd0 : r_field + 2'd1;
        end
    end

    always_comb begin
        w_ring_next      = r_ring;
        w_src_alarm_next = r_src_alarm;
        w_pre_next       = r_pre;
        w_hold_next      = r_hold;
        if (w_hit) begin
            w_ring_next      = 1'b1;
            w_src_alarm_next = Alarm_hit;
            w_pre_next       = '0;
            w_hold_next      = '0;
        end else if (r_ring) begin
            if (Ack_key || w_hold_done) begin
                w_ring_next = 1'b0;
                w_pre_next  = '0;
                w_hold_next = '0;
            end else if (w_pre_wrap) begin
                w_pre_next  = '0;
                w_hold_next = r_hold + HW'(1);
            end else begin
                w_pre_next  = r_pre + PW'(1);
            end
        end
    end

    // Restarting the blink on any accepted key keeps the edited field visible at once.
    always_comb begin
        w_blink_next = r_blink + BW'(1);
        w_phase_next = r_phase;
        if (w_mode_acc || w_field_acc || (w_hit && !r_ring)) begin
            w_blink_next = '0;
            w_phase_next = 1'b0;
        end else if (r_blink == BLINK_LAST) begin
            w_blink_next = '0;
            w_phase_next = ~r_phase;
        end
    end

    always_comb begin
        case (r_mode)
            M_CLOCK, M_CLOCK_C:       w_src_word = Clock_data;
            M_CALENDAR, M_CALENDAR_C: w_src_word = Calendar_data;
            M_ALARM:                  w_src_word = Alarm_data;
            default:                  w_src_word = Countdown_data;
        endcase
        w_disp_next = w_src_word;
        if (r_ring) begin
            if (r_phase) w_disp_next = 32'hFFFF_FFFF;
            else         w_disp_next = r_src_alarm ? Alarm_data : Countdown_data;
        end else if (Edit_en && r_phase) begin
            case (r_field)
                2'd0:    w_disp_next[31:24] = 8'hFF;
                2'd1:    w_disp_next[19:12] = 8'hFF;
                2'd2:    w_disp_next[7:0]   = 8'hFF;
                default: w_disp_next = w_src_word;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_mode      <= M_CLOCK;
            r_field     <= 2'd0;
            r_ring      <= 1'b0;
            r_src_alarm <= 1'b0;
            r_blink     <= '0;
            r_phase     <= 1'b0;
            r_pre       <= '0;
            r_hold      <= '0;
            r_disp      <= 32'd0;
        end else begin
            r_mode      <= w_mode_next;
            r_field     <= w_field_next;
            r_ring      <= w_ring_next;
            r_src_alarm <= w_src_alarm_next;
            r_blink     <= w_blink_next;
            r_phase     <= w_phase_next;
            r_pre       <= w_pre_next;
            r_hold      <= w_hold_next;
            r_disp      <= w_disp_next;
        end
    end

    assign Disp_Data  = r_disp;
    assign Mode       = r_mode;
    assign Edit_field = r_field;
    assign Ring       = r_ring;
    assign Edit_en    = w_edit_mode & ~r_ring;

endmodule

// File: tb/tb_disp_sched.sv
// Directed bench for disp_sched with short blink/second/hold counts.
module tb_disp_sched;

    localparam logic [31:0] CLK_W = 32'h12A34A56;
    localparam logic [31:0] CAL_W = 32'h25A09A04;
    localparam logic [31:0] ALM_W = 32'h07A30A00;
    localparam logic [31:0] CNT_W = 32'h00A05A30;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Mode_key = 1'b0;
    logic        Field_key = 1'b0;
    logic        Ack_key = 1'b0;
    logic        Alarm_hit = 1'b0;
    logic        Countdown_done = 1'b0;
    logic [31:0] Clock_data = CLK_W;
    logic [31:0] Calendar_data = CAL_W;
    logic [31:0] Alarm_data = ALM_W;
    logic [31:0] Countdown_data = CNT_W;
    logic [31:0] Disp_Data;
    logic [2:0]  Mode;
    logic        Edit_en;
    logic [1:0]  Edit_field;
    logic        Ring;

    int n_checks = 0;
    int n_errors = 0;

    disp_sched #(
        .MCNT_BLINK  (3),
        .MCNT_S      (7),
        .ALARM_HOLD_S(2)
    ) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .Mode_key      (Mode_key),
        .Field_key     (Field_key),
        .Ack_key       (Ack_key),
        .Alarm_hit     (Alarm_hit),
        .Countdown_done(Countdown_done),
        .Clock_data    (Clock_data),
        .Calendar_data (Calendar_data),
        .Alarm_data    (Alarm_data),
        .Countdown_data(Countdown_data),
        .Disp_Data     (Disp_Data),
        .Mode          (Mode),
        .Edit_en       (Edit_en),
        .Edit_field    (Edit_field),
        .Ring          (Ring)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 ns after each rising edge.
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic pulse_mode();
        Mode_key = 1'b1;
        step(1);
        Mode_key = 1'b0;
    endtask

    task automatic pulse_field();
        Field_key = 1'b1;
        step(1);
        Field_key = 1'b0;
    endtask

    initial begin
        logic [2:0] exp_mode;
        logic       exp_edit;

        step(2);
        chk("rst_disp", Disp_Data, 32'd0);
        chk("rst_mode", 32'(Mode), 32'd0);
        chk("rst_edit_en", 32'(Edit_en), 32'd0);
        chk("rst_field", 32'(Edit_field), 32'd0);
        chk("rst_ring", 32'(Ring), 32'd0);
        Reset = 1'b0;
        step(1);
        $display("reset: Disp_Data=%h Mode=%0d Ring=%0d", Disp_Data, Mode, Ring);

        for (int i = 0; i < 6; i++) begin
            exp_mode = 3'((i + 1) % 6);
            exp_edit = (exp_mode == 3'd1) || (exp_mode == 3'd3) || (exp_mode == 3'd4);
            pulse_mode();
            chk("walk_mode", 32'(Mode), 32'(exp_mode));
            chk("walk_edit_en", 32'(Edit_en), 32'(exp_edit));
            $display("mode key %0d: Mode=%0d Edit_en=%0d", i, Mode, Edit_en);
            if (exp_mode == 3'd2) begin
                step(1);
                chk("walk_cal_disp", Disp_Data, CAL_W);
                step(8);
            end else begin
                step(9);
            end
        end

        pulse_mode();
        pulse_field();
        chk("edit_field1", 32'(Edit_field), 32'd1);
        for (int j = 1; j <= 12; j++) begin
            step(1);
            chk("blink_f1", Disp_Data, ((((j - 1) / 4) % 2) == 1) ? 32'h12AFFA56 : CLK_W);
        end
        $display("blink field 1: last Disp_Data=%h", Disp_Data);

        pulse_field();
        chk("edit_field2", 32'(Edit_field), 32'd2);
        for (int j = 1; j <= 8; j++) begin
            step(1);
            chk("blink_f2", Disp_Data, ((((j - 1) / 4) % 2) == 1) ? 32'h12A34AFF : CLK_W);
        end
        $display("blink field 2: last Disp_Data=%h", Disp_Data);

        Mode_key = 1'b1;
        Field_key = 1'b1;
        step(1);
        Mode_key = 1'b0;
        Field_key = 1'b0;
        chk("both_mode", 32'(Mode), 32'd2);
        chk("both_field", 32'(Edit_field), 32'd0);
        $display("mode+field keys: Mode=%0d Edit_field=%0d", Mode, Edit_field);

        pulse_mode();
        pulse_field();
        chk("pre_alarm_mode", 32'(Mode), 32'd3);
        chk("pre_alarm_field", 32'(Edit_field), 32'd1);

        Alarm_hit = 1'b1;
        step(1);
        Alarm_hit = 1'b0;
        chk("ring_enter", 32'(Ring), 32'd1);
        chk("ring_edit_en", 32'(Edit_en), 32'd0);
        for (int j = 1; j <= 16; j++) begin
            if (j == 3 || j == 9) Mode_key = 1'b1;
            step(1);
            Mode_key = 1'b0;
            chk("ring_hold", 32'(Ring), (j < 16) ? 32'd1 : 32'd0);
            chk("ring_disp", Disp_Data, ((((j - 1) / 4) % 2) == 1) ? 32'hFFFF_FFFF : ALM_W);
            chk("ring_mode", 32'(Mode), 32'd3);
        end
        chk("after_ring_field", 32'(Edit_field), 32'd1);
        chk("after_ring_edit_en", 32'(Edit_en), 32'd1);
        step(1);
        chk("after_ring_disp", Disp_Data, CAL_W);
        $display("alarm timeout: Ring=%0d Mode=%0d Disp_Data=%h", Ring, Mode, Disp_Data);

        Alarm_hit = 1'b1;
        Countdown_done = 1'b1;
        step(1);
        Alarm_hit = 1'b0;
        Countdown_done = 1'b0;
        chk("prio_ring", 32'(Ring), 32'd1);
        step(1);
        chk("prio_src", Disp_Data, ALM_W);
        step(3);
        Ack_key = 1'b1;
        step(1);
        Ack_key = 1'b0;
        chk("ack_ring", 32'(Ring), 32'd0);
        chk("ack_mode", 32'(Mode), 32'd3);
        step(1);
        chk("ack_disp", Disp_Data, 32'h25AFFA04);
        $display("ack: Ring=%0d Disp_Data=%h", Ring, Disp_Data);

        Alarm_hit = 1'b1;
        step(1);
        Alarm_hit = 1'b0;
        step(2);
        Ack_key = 1'b1;
        Countdown_done = 1'b1;
        step(1);
        Ack_key = 1'b0;
        Countdown_done = 1'b0;
        chk("retrig_ring", 32'(Ring), 32'd1);
        step(1);
        chk("retrig_src", Disp_Data, CNT_W);
        step(14);
        chk("retrig_hold", 32'(Ring), 32'd1);
        step(1);
        chk("retrig_end", 32'(Ring), 32'd0);
        $display("retrigger: Ring=%0d Mode=%0d", Ring, Mode);

        Alarm_hit = 1'b1;
        step(1);
        Alarm_hit = 1'b0;
        step(2);
        chk("midring_ring", 32'(Ring), 32'd1);
        Reset = 1'b1;
        step(1);
        Reset = 1'b0;
        chk("midrst_ring", 32'(Ring), 32'd0);
        chk("midrst_mode", 32'(Mode), 32'd0);
        chk("midrst_disp", Disp_Data, 32'd0);
        chk("midrst_field", 32'(Edit_field), 32'd0);
        $display("reset mid-ring: Ring=%0d Mode=%0d Disp_Data=%h", Ring, Mode, Disp_Data);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/disp_sched.md
# disp_sched

Display scheduler for the electric clock: owns the single 8-digit hex8 display and decides which time source drives it. It walks the six operating modes on key presses, selects the matching 32-bit display word, blinks the field under edit, and lets alarm or countdown events preempt the display. It sits between the key_filter press flags and the time/calendar/alarm/countdown counters on one side, and the hex8 driver on the other.

## Interface
- MCNT_BLINK, 25_000_000-1: blink half-period terminal count, giving 1 Hz blink at 50 MHz.
- MCNT_S, 50_000_000-1: 1 s prescaler terminal count.
- ALARM_HOLD_S, 10: ring duration in seconds.
- Clk  in  1  system clock. One clock; reset is synchronous and active-high (port Reset).
- Reset  in  1  synchronous, active-high reset.
- Mode_key  in  1  one-cycle press pulse (Key_P_flag); advances mode.
- Field_key  in  1  one-cycle press pulse; advances edit field.
- Ack_key  in  1  one-cycle press pulse; dismisses ring.
- Alarm_hit  in  1  one-cycle pulse; alarm time matched.
- Countdown_done  in  1  one-cycle pulse; countdown reached zero.
- Clock_data, Calendar_data, Alarm_data, Countdown_data  in  32 each  display words, nibble layout {f0[31:24], 4'hA, f1[19:12], 4'hA, f2[7:0]}.
- Disp_Data  out  32  word to hex8.
- Mode  out  3  current mode: CLOCK=0, CLOCK_C=1, CALENDAR=2, CALENDAR_C=3, ALARM=4, COUNTER_D=5.
- Edit_en  out  1  high in modes 1, 3, 4 while not ringing.
- Edit_field  out  2  field under edit: 0=[31:24], 1=[19:12], 2=[7:0].
- Ring  out  1  preemption active.

## Operation
- Mode FSM: each accepted Mode_key advances 0→1→2→3→4→5→0. Any mode change resets Edit_field to 0. Mode never takes codes 6 or 7. If it does, the next cycle forces it to 0.
- Field_key in an edit mode cycles Edit_field 0→1→2→0. Outside edit modes it is ignored.
- Mode_key and Field_key in the same cycle: Mode_key wins and Field_key is dropped.
- Source select:
  - Modes 0 and 1 use Clock_data.
  - Modes 2 and 3 use Calendar_data.
  - Mode 4 uses Alarm_data.
  - Mode 5 uses Countdown_data.
- Blink counter:
  - Free-running, 0..MCNT_BLINK.
  - The phase bit toggles on wrap.
  - Any accepted Mode_key or Field_key clears both counter and phase, so the field is visible immediately.
- Edit blanking: with Edit_en=1 and phase=1, the 8 bits of the selected field are replaced with 4'hF,4'hF (blank code in hex8). The 4'hA separators are never blanked.
- Ring entry:
  - From idle, Alarm_hit or Countdown_done sets Ring=1.
  - Ring source is Alarm_data for Alarm_hit, Countdown_data for Countdown_done. Alarm_hit wins if both arrive together.
  - The 1 s prescaler and hold-seconds counter restart from 0. Blink counter and phase clear.
- While ringing:
  - Disp_Data shows the ring source. When phase=1, all 32 bits become 4'hF.
  - Edit_en=0.
  - Mode_key and Field_key are consumed with no effect. Mode and Edit_field hold their values.
- Retrigger: a new hit while ringing restarts the hold counters and updates the source, using the same priority.
- Ring exit: Ack_key, or the hold-seconds counter reaching ALARM_HOLD_S. Ring then drops and the saved Mode/Edit_field resume.
- Hit and Ack_key in the same cycle while ringing: the hit wins (retrigger). Ack_key while idle is ignored.

## Timing
- Reset values (applied at the Clk edge with Reset=1):
  - Disp_Data=0, Mode=0, Edit_en=0, Edit_field=0, Ring=0.
  - Blink counter, phase, prescaler and hold counter all 0.
- A key or event pulse sampled at edge N updates Mode, Edit_field, Ring and Edit_en at edge N.
- Disp_Data is registered from the registered state and source inputs. It reflects a state change at edge N+1, and source data changes one edge after they appear.
- Ring duration without ack: Ring falls exactly ALARM_HOLD_S×(MCNT_S+1) cycles after the entry edge.
- Ack_key at edge N: Ring=0 at edge N. Disp_Data returns to the mode source at edge N+1.
- The blink phase toggles every MCNT_BLINK+1 cycles, counted from reset or from the last clear.

## Test plan
All scenarios use MCNT_BLINK=3, MCNT_S=7, ALARM_HOLD_S=2, Clock_data=32'h12A34A56, Calendar_data=32'h25A09A04.
- Reset and mode walk: apply Reset, then 6 Mode_key pulses spaced by 10 cycles.
  - Mode steps 1,2,3,4,5,0.
  - Edit_en=1 only in modes 1, 3, 4.
  - Disp_Data equals Calendar_data one cycle after Mode becomes 2.
- Edit blink:
  - In mode 1 with Edit_field=1, Disp_Data alternates every 4 cycles between 32'h12A34A56 and 32'h12AFFA56.
  - Field_key moves blanking to [7:0], giving 32'h12A34AFF, and restarts the visible phase.
- Simultaneous keys: Mode_key and Field_key in the same cycle in mode 1 → Mode=2, Edit_field=0.
- Alarm timeout: Alarm_hit in mode 3.
  - Ring=1 for exactly 16 cycles.
  - Disp_Data alternates Alarm_data / 32'hFFFFFFFF.
  - Mode_key pulses during the ring are ignored. Afterward Mode=3 and Edit_field is unchanged.
- Priority and ack:
  - Alarm_hit and Countdown_done in the same cycle → source is Alarm_data.
  - Ack_key at cycle 5 → Ring=0 on the same edge.
  - Ack_key plus Countdown_done together while ringing → ring continues with Countdown_data and the hold counter restarted.
- Reset mid-ring: Reset asserted while Ring=1 → next edge gives Ring=0, Mode=0, Disp_Data=0.
